// File: rtl/sort_pkg.sv
// Shared types and sizing helpers for the odd-even transposition sorter.
package sort_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Width of the load, pass and read counters for a block of m elements.
    function automatic int cnt_width(input int m);
        return (m > 2) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/cmp_swap.sv
// Combinational compare-exchange: lo/hi ordered pair, swapped flags an exchange.
module cmp_swap #(
    parameter int N = 16
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] lo,
    output logic [N-1:0] hi,
    output logic         swapped
);

    // Strict compare keeps equal values in place.
    assign swapped = (a > b);
    assign lo      = swapped ? b : a;
    assign hi      = swapped ? a : b;

endmodule

// File: rtl/oet_sorter.sv
// Odd-even transposition sorter: load M elements, sort in M passes, stream out ascending.
module oet_sorter
    import sort_pkg::*;
#(
    parameter int N = 16,
    parameter int M = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         out_last,
    output logic         busy
);

    localparam int CW = cnt_width(M);
    localparam logic [CW-1:0] LAST_IDX = CW'(M - 1);

    if ((M < 2) || ((M % 2) != 0)) begin : g_bad_m
        $error("oet_sorter: M must be even and >= 2");
    end

    state_t        r_state;
    state_t        w_state_next;
    logic [CW-1:0] r_ld_cnt;
    logic [CW-1:0] r_p;
    logic [CW-1:0] r_rd_cnt;
    logic [N-1:0]  r_slot [M];

    logic [N-1:0]  w_even [M];
    logic [N-1:0]  w_odd  [M];
    logic [M-1:0]  w_even_sw;
    logic [M-1:0]  w_odd_sw;
    logic          w_in_fire;
    logic          w_out_fire;

    assign in_ready   = (r_state == LOAD);
    assign out_valid  = (r_state == DRAIN);
    assign busy       = (r_state != LOAD);
    assign out_last   = (r_state == DRAIN) && (r_rd_cnt == LAST_IDX);
    assign out_data   = (r_state == DRAIN) ? r_slot[r_rd_cnt] : '0;
    assign w_in_fire  = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;

    // Even pass network: pairs (0,1),(2,3),...
    for (genvar gi = 0; gi < M / 2; gi++) begin : g_even
        cmp_swap #(.N(N)) u_cs (
            .a       (r_slot[2*gi]),
            .b       (r_slot[2*gi+1]),
            .lo      (w_even[2*gi]),
            .hi      (w_even[2*gi+1]),
            .swapped (w_even_sw[2*gi])
        );
        assign w_even_sw[2*gi+1] = w_even_sw[2*gi];
    end

    // Odd pass network: pairs (1,2),...; the end slots pass through untouched.
    assign w_odd[0]       = r_slot[0];
    assign w_odd[M-1]     = r_slot[M-1];
    assign w_odd_sw[0]    = 1'b0;
    assign w_odd_sw[M-1]  = 1'b0;
    for (genvar gi = 0; gi < M / 2 - 1; gi++) begin : g_odd
        cmp_swap #(.N(N)) u_cs (
            .a       (r_slot[2*gi+1]),
            .b       (r_slot[2*gi+2]),
            .lo      (w_odd[2*gi+1]),
            .hi      (w_odd[2*gi+2]),
            .swapped (w_odd_sw[2*gi+1])
        );
        assign w_odd_sw[2*gi+2] = w_odd_sw[2*gi+1];
    end

    // Register bank: each slot writes only on its load enable or when its pair swaps.
    for (genvar gi = 0; gi < M; gi++) begin : g_bank
        logic         w_load_en;
        logic         w_pass_en;
        logic [N-1:0] w_slot_next;

        assign w_load_en   = w_in_fire && (r_ld_cnt == CW'(gi));
        assign w_pass_en   = (r_state == SORT) && (r_p[0] ? w_odd_sw[gi] : w_even_sw[gi]);
        assign w_slot_next = w_load_en ? in_data : (r_p[0] ? w_odd[gi] : w_even[gi]);

        always_ff @(posedge clk) begin
            if (rst) begin
                r_slot[gi] <= '0;
            end else if (w_load_en || w_pass_en) begin
                r_slot[gi] <= w_slot_next;
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            LOAD:    if (w_in_fire && (r_ld_cnt == LAST_IDX)) w_state_next = SORT;
            SORT:    if (r_p == LAST_IDX) w_state_next = DRAIN;
            DRAIN:   if (w_out_fire && out_last) w_state_next = LOAD;
            default: w_state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= LOAD;
            r_ld_cnt <= '0;
            r_p      <= '0;
            r_rd_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_in_fire) begin
                r_ld_cnt <= (r_ld_cnt == LAST_IDX) ? '0 : r_ld_cnt + 1'b1;
            end
            if (r_state == SORT) begin
                r_p <= (r_p == LAST_IDX) ? '0 : r_p + 1'b1;
            end
            if (w_out_fire) begin
                r_rd_cnt <= out_last ? '0 : r_rd_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_oet_sorter.sv
// Directed table-driven bench for oet_sorter with stall, gap and mid-sort reset sequences.
module tb_oet_sorter;

    localparam int N = 16;
    localparam int M = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] out_data;
    logic         out_last;
    logic         busy;

    always #5 clk = ~clk;

    oet_sorter #(.N(N), .M(M)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    typedef logic [0:M-1][N-1:0] block_t;

    typedef struct {
        block_t din;
        block_t exp;
        bit     gaps;
        bit     stall;
    } vec_t;

    int   n_checks = 0;
    int   n_errors = 0;
    vec_t tbl [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_in_ready"},  32'(in_ready),  32'd1);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_data"},  32'(out_data),  32'd0);
        check({tag, "_out_last"},  32'(out_last),  32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    // Feeds one block, then measures edges until out_valid rises (bounded).
    task automatic load_block(input block_t din, input bit gaps, input bit junk);
        int lat;
        lat = -1;
        for (int i = 0; i < M; i++) begin
            if (gaps) begin
                for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                    in_valid = 1'b0;
                    in_data  = 16'hBEEF;
                    @(posedge clk); #1;
                end
            end
            in_valid = 1'b1;
            in_data  = din[i];
            check("in_ready_load", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
        end
        in_valid = junk;
        in_data  = 16'hDEAD;
        for (int e = 1; e <= M + 4; e++) begin
            check("in_ready_sort", 32'(in_ready), 32'd0);
            check("busy_sort", 32'(busy), 32'd1);
            @(posedge clk); #1;
            if (out_valid) begin
                lat = e;
                break;
            end
        end
        check("sort_latency", 32'(lat), 32'(M));
        in_valid = 1'b0;
    endtask

    // Drains one block; odd elements optionally see out_ready held low for two cycles.
    task automatic drain_block(input block_t exp, input bit stall);
        for (int i = 0; i < M; i++) begin
            if (stall && (i % 2 == 1)) begin
                out_ready = 1'b0;
                for (int s = 0; s < 2; s++) begin
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_data",  32'(out_data),  32'(exp[i]));
                    check("stall_in_ready", 32'(in_ready), 32'd0);
                    @(posedge clk); #1;
                end
            end
            out_ready = 1'b1;
            check("out_valid", 32'(out_valid), 32'd1);
            check("out_data",  32'(out_data),  32'(exp[i]));
            check("out_last",  32'(out_last),  32'(i == M - 1));
            check("in_ready_drain", 32'(in_ready), 32'd0);
            $display("block out[%0d] = %04h (last=%0b)", i, out_data, out_last);
            @(posedge clk); #1;
        end
        check("in_ready_return", 32'(in_ready), 32'd1);
        check("out_valid_end", 32'(out_valid), 32'd0);
        check("busy_end", 32'(busy), 32'd0);
    endtask

    initial begin
        tbl[0].din = '{16'd7, 16'd3, 16'd9, 16'd1, 16'd8, 16'd2, 16'd6, 16'd4};
        tbl[0].exp = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd6, 16'd7, 16'd8, 16'd9};
        tbl[0].gaps = 1'b0; tbl[0].stall = 1'b0;
        tbl[1].din = '{16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFC, 16'hFFFB, 16'hFFFA, 16'hFFF9, 16'hFFF8};
        tbl[1].exp = '{16'hFFF8, 16'hFFF9, 16'hFFFA, 16'hFFFB, 16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF};
        tbl[1].gaps = 1'b0; tbl[1].stall = 1'b0;
        tbl[2].din = '{16'd5, 16'd5, 16'd0, 16'd5, 16'd0, 16'd0, 16'd5, 16'd0};
        tbl[2].exp = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd5, 16'd5, 16'd5, 16'd5};
        tbl[2].gaps = 1'b0; tbl[2].stall = 1'b0;
        tbl[3].din = '{16'd100, 16'h8000, 16'd3, 16'h7FFF, 16'd42, 16'd42, 16'd1, 16'd0};
        tbl[3].exp = '{16'd0, 16'd1, 16'd3, 16'd42, 16'd42, 16'd100, 16'h7FFF, 16'h8000};
        tbl[3].gaps = 1'b1; tbl[3].stall = 1'b1;
        tbl[4].din = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80};
        tbl[4].exp = '{16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60, 16'd70, 16'd80};
        tbl[4].gaps = 1'b0; tbl[4].stall = 1'b0;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        rst = 1'b0;

        // Consecutive table entries run back-to-back with no idle cycles.
        for (int v = 0; v < 5; v++) begin
            $display("vector %0d: load gaps=%0b stall=%0b", v, tbl[v].gaps, tbl[v].stall);
            load_block(tbl[v].din, tbl[v].gaps, tbl[v].stall);
            drain_block(tbl[v].exp, tbl[v].stall);
        end

        // Reset on the third SORT cycle discards the block in flight.
        for (int i = 0; i < M; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h1000 + 16'(i);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("busy_mid_sort", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        check_reset_state("mid_sort_reset");
        rst = 1'b0;
        $display("mid-sort reset applied, loading fresh block");
        begin
            block_t din_r;
            block_t exp_r;
            din_r = '{16'd2, 16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
            exp_r = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'd2};
            load_block(din_r, 1'b0, 1'b0);
            drain_block(exp_r, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
